product_bcd_converter: RTL and testbench

//   Sequential binary-to-BCD converter that sits directly downstream of the
//   4x4 multiplier. Takes the 8-bit product p and converts it to packed BCD

---
 rtl/product_bcd_converter.sv | 100 ++++++++++
 tb/tb_product_bcd_converter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// ============================================================================
// Module   : product_bcd_converter
// Purpose  : Sequential double-dabble converter, multiplier product -> packed BCD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module product_bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BCD_W-1:0]   w_corr;
   logic [SR_W-1:0]    w_shifted;

   // Every BCD nibble is corrected in parallel before the shift.
   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_nib
         assign w_corr[4*g +: 4] = (sr_q[WIDTH + 4*g +: 4] >= 4'd5)
                                 ? sr_q[WIDTH + 4*g +: 4] + 4'd3
                                 : sr_q[WIDTH + 4*g +: 4];
      end
   endgenerate

   assign w_shifted = {w_corr, sr_q[WIDTH-1:0]} << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sr_d    = {{BCD_W{1'b0}}, bin};
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d  = w_shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               bcd_d   = w_shifted[SR_W-1:WIDTH];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign bcd  = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_product_bcd_converter.sv
// ============================================================================
// Module   : tb_product_bcd_converter
// Purpose  : Directed self-checking bench for product_bcd_converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_product_bcd_converter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int checks   = 0;
   int failures = 0;

   product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Starts a conversion from IDLE (called at a negedge), returns the result
   // and the number of cycles from the accepting edge to done; lat=-1 on timeout.
   task automatic run_conv(input logic [7:0] v, output logic [11:0] res, output int lat);
      bin   = v;
      start = 1'b1;
      step();
      start = 1'b0;
      lat   = -1;
      res   = '0;
      for (int i = 0; i <= 20; i++) begin
         if (done) begin
            lat = i;
            res = bcd;
            break;
         end
         step();
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bin = '0;
      step(); step();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_zero();
      logic [11:0] r; int lat;
      run_conv(8'd0, r, lat);
      checks++;
      if (r !== 12'h000) begin failures++; $display("FAIL zero_bcd got=%h exp=000", r); end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL zero_latency got=%0d exp=8", lat); end
   endtask

   task automatic test_225();
      logic [11:0] r; int lat;
      run_conv(8'd225, r, lat);
      checks++;
      if (r !== 12'h225) begin failures++; $display("FAIL p225_bcd got=%h exp=225", r); end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL p225_latency got=%0d exp=8", lat); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL p225_done_width got=%b exp=0", done); end
      checks++;
      if (bcd !== 12'h225) begin failures++; $display("FAIL p225_hold got=%h exp=225", bcd); end
   endtask

   task automatic test_retrigger();
      logic [11:0] r1, r2; int lat1, gap;
      bin = 8'd99; start = 1'b1;
      step();
      bin = 8'd7;
      lat1 = -1; r1 = '0;
      for (int i = 0; i <= 20; i++) begin
         if (done) begin lat1 = i; r1 = bcd; break; end
         step();
      end
      checks++;
      if (r1 !== 12'h099) begin failures++; $display("FAIL retrig_first got=%h exp=099", r1); end
      checks++;
      if (lat1 !== 8) begin failures++; $display("FAIL retrig_first_lat got=%0d exp=8", lat1); end
      step();
      gap = -1; r2 = '0;
      for (int i = 1; i <= 20; i++) begin
         if (done) begin gap = i; r2 = bcd; break; end
         step();
      end
      start = 1'b0;
      checks++;
      if (r2 !== 12'h007) begin failures++; $display("FAIL retrig_second got=%h exp=007", r2); end
      checks++;
      if (gap !== 10) begin failures++; $display("FAIL retrig_throughput got=%0d exp=10", gap); end
      step();
   endtask

   task automatic test_reset_abort();
      logic [11:0] r; int lat;
      bin = 8'd255; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      checks++;
      if ({busy, done, bcd} !== 14'd0) begin
         failures++;
         $display("FAIL abort_outputs got busy=%b done=%b bcd=%h exp 0/0/000", busy, done, bcd);
      end
      rst = 1'b0;
      run_conv(8'd128, r, lat);
      checks++;
      if (r !== 12'h128) begin failures++; $display("FAIL abort_restart got=%h exp=128", r); end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL abort_restart_lat got=%0d exp=8", lat); end
   endtask

   task automatic test_ignored_start();
      logic [11:0] r; int lat; int busy_seen;
      bin = 8'd42; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      bin = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      lat = -1; r = '0;
      for (int i = 3; i <= 20; i++) begin
         if (done) begin lat = i; r = bcd; break; end
         step();
      end
      checks++;
      if (r !== 12'h042) begin failures++; $display("FAIL ignored_bcd got=%h exp=042", r); end
      checks++;
      if (lat !== 8) begin failures++; $display("FAIL ignored_lat got=%0d exp=8", lat); end
      busy_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (busy) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin failures++; $display("FAIL ignored_no_queue got=%0d exp=0", busy_seen); end
   endtask

   task automatic test_busy_done_timing();
      int busy_cnt, done_cnt, overlap;
      bin = 8'd77; start = 1'b1;
      busy_cnt = 0; done_cnt = 0; overlap = 0;
      step();
      start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (busy && done) overlap++;
         step();
      end
      checks++;
      if (busy_cnt !== 8) begin failures++; $display("FAIL timing_busy_cycles got=%0d exp=8", busy_cnt); end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL timing_done_cycles got=%0d exp=1", done_cnt); end
      checks++;
      if (overlap !== 0) begin failures++; $display("FAIL timing_overlap got=%0d exp=0", overlap); end
      checks++;
      if (bcd !== 12'h077) begin failures++; $display("FAIL timing_bcd got=%h exp=077", bcd); end
   endtask

   task automatic test_sweep();
      logic [11:0] r, e; int lat, p;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            p = a * b;
            e = 12'(((p / 100) << 8) | (((p / 10) % 10) << 4) | (p % 10));
            run_conv(8'(p), r, lat);
            checks++;
            if (r !== e || lat !== 8) begin
               failures++;
               $display("FAIL sweep a=%0d b=%0d got=%h lat=%0d exp=%h lat=8", a, b, r, lat, e);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bin = '0;
      @(negedge clk);
      test_reset();
      test_zero();
      test_225();
      test_retrigger();
      test_reset_abort();
      test_ignored_start();
      test_busy_done_timing();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
